uart_hex_cmd_parser: RTL and testbench
======================================

# uart_hex_cmd_parser

Receive-side command parser sitting between the UART receiver and the seven-segment display interface. Consumes received bytes, assembles ASCII hex digits into a display word, and on a line terminator commits the word to the display with a one-cycle write strobe. Optionally echoes every received byte back through the UART transmitter via a small FIFO, giving a terminal-driven display.

## Interface
- DIGITS, 6, number of hex digits accepted; display word width W = 4*DIGITS
- ECHO_DEPTH, 4, echo FIFO depth, power of two, ≥2
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe, byte available
- disp_data  out  W  committed display word
- disp_wen  out  1  one-cycle strobe, disp_data updated
- err  out  1  one-cycle strobe, line rejected
- tx_data  out  8  echo byte to transmitter
- tx_write  out  1  one-cycle transmit kickoff
- tx_ready  in  1  transmitter idle
- echo_drop  out  1  one-cycle strobe, echo byte lost (FIFO full)

## Operation
- States: IDLE (count=0), ACCUM (1..DIGITS digits held), DISCARD (bad line, waiting for terminator).
- Hex digit ('0'-'9' = 0x30-0x39, 'A'-'F', 'a'-'f'): acc <= {acc[W-5:0], nibble}, count+1, IDLE/ACCUM -> ACCUM. Digit when count==DIGITS -> DISCARD, err pulse.
- Terminator CR 0x0D or LF 0x0A: in ACCUM -> disp_data <= acc, disp_wen pulse, acc/count cleared, -> IDLE. In IDLE: ignored (CRLF commits once). In DISCARD: -> IDLE, no commit, no err.
- Backspace 0x08: ACCUM -> acc >>= 4, count-1; count 1->0 returns to IDLE. Ignored in IDLE and DISCARD.
- ESC 0x1B: clears acc/count, -> IDLE from any state, no err.
- Any other byte in IDLE/ACCUM: -> DISCARD, err pulse; acc cleared. Ignored in DISCARD.
- Fewer than DIGITS digits commit zero-extended in upper nibbles (e.g. "1F" -> 0x00001F).
- Echo path: every rx_valid byte (including illegal ones) pushed into echo FIFO. Pop when FIFO non-empty, tx_ready=1 and holdoff counter zero; pop drives tx_data and asserts tx_write one cycle, then holdoff 2 cycles before tx_ready is sampled again (covers transmitter's ready-drop latency).
- Push on full FIFO: byte not stored, echo_drop pulse; parser still processes the byte. Push and pop in same cycle on full FIFO: push accepted.

## Timing
- All outputs registered. Reset values: disp_data 0, disp_wen 0, err 0, tx_data 0, tx_write 0, echo_drop 0; state IDLE, acc 0, count 0, FIFO empty, holdoff 0.
- rx_valid at cycle n -> state/acc updated at edge n+1; disp_wen/err/echo_drop high during cycle n+1 only; disp_data valid from n+1 and held until next commit.
- Byte pushed at n: earliest tx_write at n+2 (FIFO empty, tx_ready=1, holdoff 0).
- Back-to-back rx_valid on consecutive cycles supported, one byte per cycle.
- rx_valid ignored while rst_n=0; reset mid-line or mid-echo discards partial word and all queued echo bytes; tx_write forced low.

## Configuration
- HEX_ECHO_EN defined: echo FIFO and transmit handshake present as above.
- Undefined: FIFO and holdoff logic removed; tx_data=0, tx_write=0, echo_drop=0 constant; tx_ready unused; parser behaviour unchanged.

## Structure
- Package uart_cmd_pkg: ASCII constants (CR, LF, BS, ESC), state encoding, nibble-decode function returning {valid, nibble}.
- One sub-module: echo_fifo (synchronous FIFO, ECHO_DEPTH x 8, push/pop/full/empty), instantiated only under HEX_ECHO_EN.

## Test plan
- Bytes "12AbEf" then 0x0D -> single disp_wen, disp_data=0x12ABEF; err never set.
- "7", 0x0D, 0x0A -> one disp_wen with disp_data=0x000007; LF produces nothing.
- "12G3", 0x0D -> err pulse on 'G', no disp_wen; following "5", 0x0D -> disp_data=0x000005.
- "1234567" (7 digits) -> err on 7th digit; "AB", 0x08, "C", 0x0D -> disp_data=0x0000AC.
- HEX_ECHO_EN, tx_ready held 0, 6 bytes at ECHO_DEPTH=4 -> echo_drop on bytes 5 and 6; release tx_ready -> 4 tx_write pulses, first 4 bytes in order, ≥3 cycles apart.
- "12", assert rst_n=0 one cycle, then "3", 0x0D -> disp_data=0x000003, no echo of "12".

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART hex command parser: the ASCII control
// characters it recognises, the parser state encoding, and a decoder that
// turns an ASCII character into a hex nibble.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } parser_state_e;

  // Returns {valid, nibble}; valid is 0 for anything that is not 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'h00;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      res = {1'b1, ch[3:0]};
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // Upper and lower case letters share the low nibble 1..6
      res = {1'b1, ch[3:0] + 4'h9};
    end else begin
      res = 5'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_hex_cmd_parser_echo_fifo.sv
// Small synchronous byte FIFO feeding the echo transmitter.
// Only built when HEX_ECHO_EN is defined. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise the byte is dropped.
`ifdef HEX_ECHO_EN
module echo_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        do_push_s;
  logic        do_pop_s;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o   = mem_q[rptr_q[AW-1:0]];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage and pointer update; reset flushes every queued byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/uart_hex_cmd_parser.sv
// UART receive-side hex command parser: assembles ASCII hex digits into a
// display word and commits it on CR/LF with a one-cycle write strobe.
// Optional feature macro: HEX_ECHO_EN -- echoes every received byte back to
// the transmitter through echo_fifo with a post-write holdoff.
module uart_hex_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned ECHO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [4*DIGITS-1:0]   disp_data_o,
  output logic                  disp_wen_o,
  output logic                  err_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_write_o,
  input  logic                  tx_ready_i,
  output logic                  echo_drop_o
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  parser_state_e state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  disp_data_q, disp_data_d;
  logic          disp_wen_q, disp_wen_d;
  logic          err_q, err_d;
  logic [4:0]    dec_s;

  assign dec_s = hex_decode(rx_data_i);

  // Parser next state: one received byte per cycle at most
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    disp_data_d = disp_data_q;
    disp_wen_d  = 1'b0;
    err_d       = 1'b0;
    if (rx_valid_i) begin
      if (rx_data_i == ASCII_ESC) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        count_d = '0;
      end else if (dec_s[4]) begin
        case (state_q)
          ST_IDLE, ST_ACCUM: begin
            if (count_q == CNT_MAX) begin
              state_d = ST_DISCARD;
              err_d   = 1'b1;
              acc_d   = '0;
              count_d = '0;
            end else begin
              state_d = ST_ACCUM;
              acc_d   = {acc_q[W-5:0], dec_s[3:0]};
              count_d = count_q + CNT_ONE;
            end
          end
          ST_DISCARD: state_d = ST_DISCARD;
          default:    state_d = ST_IDLE;
        endcase
      end else if (rx_data_i == ASCII_CR || rx_data_i == ASCII_LF) begin
        case (state_q)
          ST_ACCUM: begin
            disp_data_d = acc_q;
            disp_wen_d  = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            state_d     = ST_IDLE;
          end
          ST_DISCARD: state_d = ST_IDLE;
          ST_IDLE:    state_d = ST_IDLE;
          default:    state_d = ST_IDLE;
        endcase
      end else if (rx_data_i == ASCII_BS) begin
        if (state_q == ST_ACCUM) begin
          acc_d   = {4'h0, acc_q[W-1:4]};
          count_d = count_q - CNT_ONE;
          state_d = (count_q == CNT_ONE) ? ST_IDLE : ST_ACCUM;
        end else begin
          state_d = state_q;
        end
      end else begin
        if (state_q != ST_DISCARD) begin
          state_d = ST_DISCARD;
          err_d   = 1'b1;
          acc_d   = '0;
          count_d = '0;
        end else begin
          state_d = ST_DISCARD;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Parser state and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      disp_data_q <= '0;
      disp_wen_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      disp_data_q <= disp_data_d;
      disp_wen_q  <= disp_wen_d;
      err_q       <= err_d;
    end
  end

  assign disp_data_o = disp_data_q;
  assign disp_wen_o  = disp_wen_q;
  assign err_o       = err_q;

`ifdef HEX_ECHO_EN
  // Holdoff covers the transmitter's delay in dropping tx_ready after a write
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_rdata_s;
  logic       pop_s;
  logic [1:0] holdoff_q, holdoff_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_write_q;
  logic       echo_drop_q, echo_drop_d;

  echo_fifo #(.DEPTH(ECHO_DEPTH)) u_echo_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_valid_i),
    .pop_i   (pop_s),
    .wdata_i (rx_data_i),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Echo pop decision, holdoff countdown and overflow detection
  always_comb begin
    pop_s       = 1'b0;
    holdoff_d   = holdoff_q;
    tx_data_d   = tx_data_q;
    echo_drop_d = 1'b0;
    if (!fifo_empty_s && tx_ready_i && (holdoff_q == 2'd0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (pop_s) begin
      holdoff_d = HOLDOFF;
      tx_data_d = fifo_rdata_s;
    end else if (holdoff_q != 2'd0) begin
      holdoff_d = holdoff_q - 2'd1;
    end else begin
      holdoff_d = holdoff_q;
    end
    // A full FIFO still takes the byte when a pop frees a slot this cycle
    echo_drop_d = rx_valid_i && fifo_full_s && !pop_s;
  end

  // Registered transmit handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdoff_q   <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_write_q  <= 1'b0;
      echo_drop_q <= 1'b0;
    end else begin
      holdoff_q   <= holdoff_d;
      tx_data_q   <= tx_data_d;
      tx_write_q  <= pop_s;
      echo_drop_q <= echo_drop_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_write_o  = tx_write_q;
  assign echo_drop_o = echo_drop_q;
`else
  logic unused_tx_ready_s;
  assign unused_tx_ready_s = tx_ready_i;
  assign tx_data_o   = 8'h00;
  assign tx_write_o  = 1'b0;
  assign echo_drop_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Directed self-checking bench for uart_hex_cmd_parser (DIGITS=6, ECHO_DEPTH=4).
// Echo checks are active when HEX_ECHO_EN is defined; otherwise the echo
// outputs are checked to stay at zero.
module tb_uart_hex_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [23:0] disp_data;
  logic        disp_wen;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_ready = 1'b1;
  logic        echo_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wen_cnt  = 0;
  int err_cnt  = 0;
  int drop_cnt = 0;
  int tx_cnt   = 0;
  logic [7:0] tx_log  [256];
  int         tx_time [256];

  uart_hex_cmd_parser #(.DIGITS(6), .ECHO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .disp_data_o (disp_data),
    .disp_wen_o  (disp_wen),
    .err_o       (err),
    .tx_data_o   (tx_data),
    .tx_write_o  (tx_write),
    .tx_ready_i  (tx_ready),
    .echo_drop_o (echo_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and transmit log sampled away from the active edge
  always @(negedge clk) begin
    if (disp_wen)  wen_cnt  = wen_cnt + 1;
    if (err)       err_cnt  = err_cnt + 1;
    if (echo_drop) drop_cnt = drop_cnt + 1;
    if (tx_write && tx_cnt < 256) begin
      tx_log[tx_cnt]  = tx_data;
      tx_time[tx_cnt] = cyc;
      tx_cnt = tx_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte for one cycle; returns at the negedge after it was sampled
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    n_checks++; if (disp_data !== 24'h0) begin n_fail++; $display("FAIL reset_disp_data: got %h expected 000000", disp_data); end
    n_checks++; if (disp_wen !== 1'b0) begin n_fail++; $display("FAIL reset_disp_wen: got %b expected 0", disp_wen); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (tx_write !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got %b/%h expected 0/00", tx_write, tx_data); end
    n_checks++; if (echo_drop !== 1'b0) begin n_fail++; $display("FAIL reset_echo_drop: got %b expected 0", echo_drop); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_word;
    int w0, e0;
    w0 = wen_cnt; e0 = err_cnt;
    send("1"); send("2"); send("A"); send("b"); send("E"); send("f");
    n_checks++; if (disp_wen !== 1'b0) begin n_fail++; $display("FAIL full_no_early_wen: got %b expected 0", disp_wen); end
    send(8'h0D);
    n_checks++; if (disp_wen !== 1'b1 || disp_data !== 24'h12ABEF) begin n_fail++; $display("FAIL full_commit: got wen=%b data=%h expected 1/12abef", disp_wen, disp_data); end
    idle(1);
    n_checks++; if (disp_wen !== 1'b0) begin n_fail++; $display("FAIL full_wen_one_cycle: got %b expected 0", disp_wen); end
    idle(2);
    n_checks++; if (wen_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL full_counts: got wen=%0d err=%0d expected 1/0", wen_cnt - w0, err_cnt - e0); end
  endtask

  task automatic test_crlf;
    int w0;
    w0 = wen_cnt;
    send("7"); send(8'h0D); send(8'h0A);
    idle(3);
    n_checks++; if (wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL crlf_single_commit: got %0d expected 1", wen_cnt - w0); end
    n_checks++; if (disp_data !== 24'h000007) begin n_fail++; $display("FAIL crlf_data: got %h expected 000007", disp_data); end
  endtask

  task automatic test_bad_char;
    int w0, e0;
    w0 = wen_cnt; e0 = err_cnt;
    send("1"); send("2"); send("G");
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse: got %b expected 1", err); end
    send("3"); send(8'h0D);
    idle(2);
    n_checks++; if (wen_cnt - w0 !== 0 || err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_counts: got wen=%0d err=%0d expected 0/1", wen_cnt - w0, err_cnt - e0); end
    send("5"); send(8'h0D);
    idle(2);
    n_checks++; if (disp_data !== 24'h000005 || wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL bad_recover: got %h wen=%0d expected 000005/1", disp_data, wen_cnt - w0); end
  endtask

  task automatic test_overflow_bs;
    int w0, e0;
    w0 = wen_cnt; e0 = err_cnt;
    send("1"); send("2"); send("3"); send("4"); send("5"); send("6");
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_six_ok: got err=%b expected 0", err); end
    send("7");
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_7th: got %b expected 1", err); end
    send(8'h0D);
    idle(2);
    n_checks++; if (wen_cnt - w0 !== 0 || err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ovf_discard: got wen=%0d err=%0d expected 0/1", wen_cnt - w0, err_cnt - e0); end
    send("A"); send("B"); send(8'h08); send("C"); send(8'h0D);
    idle(2);
    n_checks++; if (disp_data !== 24'h0000AC) begin n_fail++; $display("FAIL bs_data: got %h expected 0000ac", disp_data); end
    // Backspace of the only digit returns to idle, so the terminator commits nothing
    w0 = wen_cnt;
    send("9"); send(8'h08); send(8'h0D);
    // ESC abandons a partial line without an error
    send("4"); send(8'h1B); send(8'h0D);
    idle(2);
    n_checks++; if (wen_cnt - w0 !== 0 || err_cnt - e0 !== 1 || disp_data !== 24'h0000AC) begin n_fail++; $display("FAIL bs_esc_no_commit: got wen=%0d err=%0d data=%h expected 0/1/0000ac", wen_cnt - w0, err_cnt - e0, disp_data); end
  endtask

  task automatic test_echo;
`ifdef HEX_ECHO_EN
    int t0, d0;
    logic [7:0] exp_b;
    logic       exp_drop;
    tx_ready = 1'b1;
    idle(40);
    // Latency from an empty FIFO: tx_write two cycles after the byte
    t0 = tx_cnt;
    send(8'h1B);
    n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL echo_not_early: got %b expected 0", tx_write); end
    idle(1);
    n_checks++; if (tx_write !== 1'b1 || tx_data !== 8'h1B) begin n_fail++; $display("FAIL echo_latency: got %b/%h expected 1/1b", tx_write, tx_data); end
    idle(5);
    tx_ready = 1'b0;
    idle(2);
    t0 = tx_cnt; d0 = drop_cnt;
    for (int i = 0; i < 6; i++) begin
      exp_b = 8'h31 + 8'(i);
      exp_drop = (i >= 4);
      send(exp_b);
      n_checks++; if (echo_drop !== exp_drop) begin n_fail++; $display("FAIL echo_drop_byte%0d: got %b expected %b", i + 1, echo_drop, exp_drop); end
    end
    idle(2);
    n_checks++; if (tx_cnt - t0 !== 0 || drop_cnt - d0 !== 2) begin n_fail++; $display("FAIL echo_held: got tx=%0d drops=%0d expected 0/2", tx_cnt - t0, drop_cnt - d0); end
    tx_ready = 1'b1;
    idle(25);
    n_checks++; if (tx_cnt - t0 !== 4) begin n_fail++; $display("FAIL echo_count: got %0d expected 4", tx_cnt - t0); end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h31 + 8'(i);
      n_checks++; if (tx_log[t0 + i] !== exp_b) begin n_fail++; $display("FAIL echo_byte%0d: got %h expected %h", i, tx_log[t0 + i], exp_b); end
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (tx_time[t0 + i] - tx_time[t0 + i - 1] < 3) begin n_fail++; $display("FAIL echo_spacing%0d: got %0d expected >=3", i, tx_time[t0 + i] - tx_time[t0 + i - 1]); end
    end
    send(8'h1B);
    idle(10);
`else
    idle(2);
    n_checks++; if (tx_cnt !== 0 || drop_cnt !== 0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL echo_disabled: got tx=%0d drops=%0d data=%h expected 0/0/00", tx_cnt, drop_cnt, tx_data); end
`endif
  endtask

  task automatic test_reset_midline;
    int t0, w0;
    tx_ready = 1'b1;
    idle(20);
    tx_ready = 1'b0;
    t0 = tx_cnt;
    send("1"); send("2");
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    n_checks++; if (disp_data !== 24'h0) begin n_fail++; $display("FAIL midreset_disp_cleared: got %h expected 000000", disp_data); end
    tx_ready = 1'b1;
    w0 = wen_cnt;
    send("3"); send(8'h0D);
    idle(20);
    n_checks++; if (disp_data !== 24'h000003 || wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL midreset_data: got %h wen=%0d expected 000003/1", disp_data, wen_cnt - w0); end
`ifdef HEX_ECHO_EN
    n_checks++; if (tx_cnt - t0 !== 2 || tx_log[t0] !== 8'h33 || tx_log[t0 + 1] !== 8'h0D) begin n_fail++; $display("FAIL midreset_echo: got n=%0d first=%h second=%h expected 2/33/0d", tx_cnt - t0, tx_log[t0], tx_log[t0 + 1]); end
`else
    n_checks++; if (tx_cnt - t0 !== 0) begin n_fail++; $display("FAIL midreset_no_echo: got %0d expected 0", tx_cnt - t0); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_full_word;
    test_crlf;
    test_bad_char;
    test_overflow_bs;
    test_echo;
    test_reset_midline;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
